// File: rtl/cic_decim_mc_pkg.sv
// cic_pkg: shared types and helpers for the multi-channel CIC decimator.
// Holds the FSM state type, the accumulator width helper and the PDM bit weights.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMB = 2'd1,
    EMIT = 2'd2
  } cic_state_t;

  // Bit growth of an N-stage CIC with decimation R and differential delay M, plus sign.
  function automatic int cic_acc_w(input int n, input int r, input int m);
    return 1 + n * $clog2(r * m);
  endfunction

  // Weight of a PDM '1' and a PDM '0' bit.
  localparam int PDM_POS = 1;
  localparam int PDM_NEG = -1;

endpackage

// File: rtl/cic_decim_mc_if.sv
// cic_decim_mc_if: channel-tagged PCM output stream (valid/ready).
// master = the decimator driving samples, slave = the downstream consumer.
interface cic_decim_mc_if #(
  parameter int OUT_WIDTH = 16,
  parameter int CH_W      = 1
) ();

  logic signed [OUT_WIDTH-1:0] dout;
  logic        [CH_W-1:0]      dout_ch;
  logic                        dout_valid;
  logic                        dout_ready;

  modport master (
    output dout,
    output dout_ch,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_ch,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/cic_comb_chain.sv
// cic_comb_chain: combinational N-stage comb for one channel.
// Each stage computes y = x - x[n-M] from its M-deep tap line; taps[k][0] is the
// newest entry of stage k and taps[k][M-1] the oldest. taps_next is the tap line
// after shifting in this sample; the caller stores it only for the active channel.
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter int ACC_W = 21,
  parameter int N     = 4,
  parameter int M     = 1
) (
  input  logic signed [ACC_W-1:0]           x,
  input  logic [N-1:0][M-1:0][ACC_W-1:0]    taps,
  output logic signed [ACC_W-1:0]           y,
  output logic [N-1:0][M-1:0][ACC_W-1:0]    taps_next
);

  logic signed [ACC_W-1:0] stage_s [N+1];

  assign stage_s[0] = x;

  for (genvar k = 0; k < N; k++) begin : g_stage
    // Difference against the oldest tap; wraps modulo 2^ACC_W by design.
    assign stage_s[k+1]    = stage_s[k] - $signed(taps[k][M-1]);
    assign taps_next[k][0] = stage_s[k];
    if (M > 1) begin : g_shift
      assign taps_next[k][M-1:1] = taps[k][M-2:0];
    end
  end

  assign y = stage_s[N];

endmodule

// File: rtl/cic_decim_mc.sv
// cic_decim_mc: NCH-channel CIC decimator with per-channel integrators running at
// PDM rate and a single comb engine time-shared across channels.
// Optional build macro CIC_ROUND_SAT_EN: round half up and saturate the output
// word instead of plain MSB truncation (same latency).
module cic_decim_mc
  import cic_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int R         = 24,
  parameter int N         = 4,
  parameter int M         = 1,
  parameter int OUT_WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           pdm_en,
  input  logic [NCH-1:0] pdm_in,
  cic_decim_mc_if.master m_if,
  output logic           overrun
);

  localparam int ACC_W = cic_acc_w(N, R, M);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = (R > 1) ? $clog2(R) : 1;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(R - 1);
  localparam logic [CH_W-1:0]         CH_LAST  = CH_W'(NCH - 1);
  localparam logic signed [ACC_W-1:0] STEP_POS = ACC_W'(PDM_POS);
  localparam logic signed [ACC_W-1:0] STEP_NEG = ACC_W'(PDM_NEG);

  typedef logic [N-1:0][M-1:0][ACC_W-1:0] taps_t;

`ifdef CIC_ROUND_SAT_EN
  localparam int                      SH     = ACC_W - OUT_WIDTH;
  localparam int                      RND_SH = (SH > 0) ? SH - 1 : 0;
  localparam logic [ACC_W:0]          RND    = (SH > 0) ? ((ACC_W+1)'(1) << RND_SH) : (ACC_W+1)'(0);
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`endif

  // Map a full-width comb result onto the output word.
  function automatic logic signed [OUT_WIDTH-1:0] to_out(input logic signed [ACC_W-1:0] v);
    logic signed [OUT_WIDTH-1:0] res;
`ifdef CIC_ROUND_SAT_EN
    logic [ACC_W:0]     rsum;
    logic [OUT_WIDTH:0] rq;
    // One guard bit above ACC_W so the rounding add cannot wrap.
    rsum = {v[ACC_W-1], v} + RND;
    rq   = rsum[ACC_W -: OUT_WIDTH+1];
    if (rq[OUT_WIDTH] != rq[OUT_WIDTH-1]) begin
      res = rq[OUT_WIDTH] ? OUT_MIN : OUT_MAX;
    end else begin
      res = rq[OUT_WIDTH-1:0];
    end
`else
    res = v[ACC_W-1 -: OUT_WIDTH];
`endif
    return res;
  endfunction

  // State
  logic signed [ACC_W-1:0] integ_q [NCH][N];
  logic signed [ACC_W-1:0] integ_d [NCH][N];
  logic signed [ACC_W-1:0] snap_q  [NCH];
  logic signed [ACC_W-1:0] snap_d  [NCH];
  taps_t                   dly_q   [NCH];
  taps_t                   dly_d   [NCH];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  cic_state_t              state_q, state_d;
  logic signed [OUT_WIDTH-1:0] dout_q, dout_d;
  logic [CH_W-1:0]         dout_ch_q, dout_ch_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic                    tick_s;
  logic signed [ACC_W-1:0] comb_y_s;
  taps_t                   comb_taps_s;

  assign tick_s = pdm_en && (cnt_q == CNT_LAST);

  // Shared comb engine, fed by the snapshot and delay line of the current channel.
  cic_comb_chain #(
    .ACC_W (ACC_W),
    .N     (N),
    .M     (M)
  ) u_comb (
    .x         (snap_q[ch_q]),
    .taps      (dly_q[ch_q]),
    .y         (comb_y_s),
    .taps_next (comb_taps_s)
  );

  // Integrator cascade: stage 0 accumulates +/-1, stage k adds the old value of stage k-1.
  always_comb begin
    integ_d = integ_q;
    if (pdm_en) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < N; k++) begin
          if (k == 0) begin
            integ_d[c][0] = integ_q[c][0] + (pdm_in[c] ? STEP_POS : STEP_NEG);
          end else begin
            integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
          end
        end
      end
    end else begin
      integ_d = integ_q;
    end
  end

  // Decimation counter, advancing only on PDM enables.
  always_comb begin
    cnt_d = cnt_q;
    if (pdm_en) begin
      cnt_d = (cnt_q == CNT_LAST) ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Comb-sharing FSM: snapshot on tick, one COMB cycle per channel, hold in EMIT.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    snap_d    = snap_q;
    dly_d     = dly_q;
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (tick_s) begin
          for (int c = 0; c < NCH; c++) begin
            snap_d[c] = integ_q[c][N-1];
          end
          ch_d    = {CH_W{1'b0}};
          state_d = COMB;
        end else begin
          state_d = IDLE;
        end
      end
      COMB: begin
        dly_d[ch_q] = comb_taps_s;
        dout_d      = to_out(comb_y_s);
        dout_ch_d   = ch_q;
        valid_d     = 1'b1;
        state_d     = EMIT;
      end
      EMIT: begin
        if (valid_q && m_if.dout_ready) begin
          valid_d = 1'b0;
          if (ch_q == CH_LAST) begin
            state_d = IDLE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = COMB;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Sticky overrun: any tick that arrives while the comb sequence is busy is dropped.
  always_comb begin
    overrun_d = overrun_q;
    if (tick_s && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      integ_q   <= '{default: '0};
      snap_q    <= '{default: '0};
      dly_q     <= '{default: '0};
      cnt_q     <= {CNT_W{1'b0}};
      ch_q      <= {CH_W{1'b0}};
      state_q   <= IDLE;
      dout_q    <= {OUT_WIDTH{1'b0}};
      dout_ch_q <= {CH_W{1'b0}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      integ_q   <= integ_d;
      snap_q    <= snap_d;
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      state_q   <= state_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_if.dout       = dout_q;
  assign m_if.dout_ch    = dout_ch_q;
  assign m_if.dout_valid = valid_q;
  assign overrun         = overrun_q;

endmodule
